demux_deser8: RTL and testbench
===============================

Name: demux_deser8

Overview:
- Receive-side counterpart of the team's 8:1 mux selector path. The mux collapses eight lines onto one output under a 3-bit select; this block takes one serial line and steers each accepted bit into slot `data[sel]` of an 8-bit word, where `sel` comes from an internal 3-bit slot counter.
- Completed words are presented on a valid/ready output port.
- A single skid/staging word lets the next word start assembling while the output is stalled.
- It sits between a serial bit source and any parallel consumer in the lab datapath.

Parameters:
- WIDTH, 8: word width / number of demux slots; must be a power of 2, at least 2.
- SEL_W, 3: slot-counter width; must equal log2(WIDTH).
- MSB_FIRST, 1: 1 = first accepted bit lands in slot WIDTH-1 (matches the {a,b,c} MSB-first select order); 0 = first bit lands in slot 0.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- clr, input, 1: synchronous abort of the partial word.
- din, input, 1: serial data bit.
- din_valid, input, 1: din is valid this cycle.
- din_ready, output, 1: block can accept din this cycle.
- out_data, output, WIDTH: assembled word.
- out_valid, output, 1: out_data holds a complete word.
- out_ready, input, 1: consumer accepts out_data this cycle.
- slot, output, SEL_W: current demux select, i.e. the slot the next bit will fill.

Behaviour:
- **Reset (rst=1 at a clk edge):**
  - Slot counter, assembly register, staging register, staging_full, out_data and out_valid all clear to 0.
  - din_ready is 1 in the cycle after reset.
  - rst has priority over every other input; reset in the middle of a word discards all partial, staged and held data.
- **Bit acceptance:**
  - A bit is accepted when din_valid and din_ready are both 1 at a clk edge.
  - Slot index = cnt if MSB_FIRST=0, otherwise WIDTH-1-cnt.
  - Only the addressed bit of the assembly register is written; cnt increments by 1.
  - `slot` shows the index for the next accept (combinational from cnt).
- **Word completion (bit accepted with cnt = WIDTH-1):**
  - cnt wraps to 0.
  - If the output is free (out_valid=0, or out_ready=1 this cycle): out_data takes the full word (including this bit) and out_valid=1 at the next edge. Latency is 1 cycle from the last accepted bit to out_valid.
  - Otherwise the word goes to staging and staging_full=1.
- **din_ready = !staging_full.**
  - While the output is stalled, a second word may assemble into the assembly register.
  - Once a word is staged, input stalls until staging drains.
- **Output handshake:**
  - out_valid && out_ready at an edge consumes the held word.
  - At the same edge: if staging_full, out_data takes the staged word, out_valid stays 1 and staging_full=0. Else, if a word completes this same edge, that word loads. Else out_valid=0.
  - out_data is stable while out_valid=1 and out_ready=0.
- **Simultaneous events:**
  - A completion and a consume in the same edge: the new word goes directly into out_data, out_valid stays 1, and no bubble is inserted.
  - A completion is not possible while staging_full, because din_ready=0.
- **clr:**
  - Sets cnt=0 and zeroes the assembly register.
  - Does not touch out_data, out_valid or staging.
  - If clr and an accept occur in the same cycle, clr wins and the bit is dropped.
- **States (2-bit encoding):**
  - EMPTY: out_valid=0.
  - HOLD: out_valid=1, staging_full=0.
  - FULL: out_valid=1, staging_full=1.
  - Transitions: EMPTY→HOLD on completion; HOLD→EMPTY on consume with no completion; HOLD→FULL on completion without consume; FULL→HOLD on consume.
- **Width rules:** cnt is exactly SEL_W bits and wraps modulo WIDTH; no other arithmetic.

Decomposition:
- Shared package holds:
  - State encoding constants EMPTY=2'd0, HOLD=2'd1, FULL=2'd2.
  - Default WIDTH/SEL_W constants.
- One natural sub-module: `demux1to8_reg`, the registered 1:WIDTH bit-steering demux (write-enable decoded from slot, with clear). It is instantiated once for the assembly register.

Test Plan:
- **MSB-first word:** MSB_FIRST=1, out_ready=1, din_valid=1 for 8 cycles with din=1,0,1,1,0,0,1,0 → out_data=8'hB2, out_valid=1 exactly one cycle after the 8th bit, high for one cycle.
- **LSB-first word:** MSB_FIRST=0, same bit stream → out_data=8'h4D; slot counts 0..7 and wraps to 0.
- **Backpressure:** out_ready=0; send 8'hB2 then 8'h5A → after the 2nd word din_ready=0 and out_data stays 8'hB2. Raise out_ready for 1 cycle → out_data=8'h5A, out_valid=1, din_ready=1. Raise it again → out_valid=0.
- **Back-to-back:** continuous bits with out_ready=1 → words on consecutive 8-cycle boundaries, no gaps, din_ready never deasserts.
- **clr mid-word:** 3 bits (1,1,1), then clr together with din_valid → slot=7 (MSB_FIRST=1); the next 8 bits 0x0F-pattern produce exactly 8'h0F.
- **Reset mid-operation:** FULL state (two words held), assert rst one cycle → out_valid=0, din_ready=1, slot=WIDTH-1, out_data=0.

Source files
------------

// File: rtl/demux_deser8_pkg.sv
// Shared constants and types for the serial-to-parallel demux deserializer.
package demux_deser8_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SEL_W = 3;

  // Output-side occupancy: nothing held, one word held, held word plus staged word.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/demux_deser8_if.sv
// Serial input / parallel output bundle for demux_deser8.
interface demux_deser8_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  logic             clr;
  logic             din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] slot;

  // Bit source and word consumer side.
  modport master (
    output clr, din, din_valid, out_ready,
    input  din_ready, out_data, out_valid, slot
  );

  // Deserializer side.
  modport slave (
    input  clr, din, din_valid, out_ready,
    output din_ready, out_data, out_valid, slot
  );
endinterface

// File: rtl/demux1to8_reg.sv
// Registered 1:WIDTH bit-steering demux: writes d into bit sel when we is high.
module demux1to8_reg #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [SEL_W-1:0] sel,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  // Only the addressed bit changes; reset and clear zero the whole word.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (we) begin
      q[sel] <= d;
    end
  end

endmodule

// File: rtl/demux_deser8.sv
// Serial bit stream to WIDTH-bit words, with one staging word behind the output.
module demux_deser8
  import demux_deser8_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  demux_deser8_if.slave     bus
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cnt;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] asm_q;
  logic [WIDTH-1:0] word_next;
  logic [WIDTH-1:0] stage_q;
  logic [WIDTH-1:0] out_q;
  logic             accept;
  logic             complete;
  logic             load_out;
  logic             load_from_stage;
  logic             load_stage;

  // WIDTH is a power of two, so WIDTH-1-cnt is just the bitwise inverse of cnt.
  assign sel           = (MSB_FIRST != 0) ? ~cnt : cnt;
  assign bus.slot      = sel;
  assign bus.din_ready = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = out_q;
  assign accept        = bus.din_valid && bus.din_ready && !bus.clr;
  assign complete      = accept && (&cnt);

  demux1to8_reg #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_asm (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr),
    .we  (accept),
    .sel (sel),
    .d   (bus.din),
    .q   (asm_q)
  );

  // Completed word as it will look once the current bit lands.
  always_comb begin
    word_next      = asm_q;
    word_next[sel] = bus.din;
  end

  // Occupancy next-state and routing of completed/staged words to the output.
  always_comb begin
    state_d         = state_q;
    load_out        = 1'b0;
    load_from_stage = 1'b0;
    load_stage      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (complete) begin
          state_d  = HOLD;
          load_out = 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (complete) load_out = 1'b1;
          else          state_d  = EMPTY;
        end else if (complete) begin
          state_d    = FULL;
          load_stage = 1'b1;
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          state_d         = HOLD;
          load_from_stage = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, slot counter, output and staging registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt     <= '0;
      out_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_out)             out_q <= word_next;
      else if (load_from_stage) out_q <= stage_q;
      if (load_stage) stage_q <= word_next;
      if (bus.clr)     cnt <= '0;
      else if (accept) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_deser8.sv
// Self-checking bench: MSB-first and LSB-first instances driven by one stream.
module tb_demux_deser8;
  import demux_deser8_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  demux_deser8_if #(.WIDTH(8), .SEL_W(3)) bus_m ();
  demux_deser8_if #(.WIDTH(8), .SEL_W(3)) bus_l ();

  demux_deser8 #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  demux_deser8 #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  // Reference model: partial word as a bit count plus value, output side as a
  // depth-2 FIFO (front = presented word, second entry = staged word).
  int         m_cnt  [2];
  logic [7:0] m_asm  [2];
  logic [7:0] m_fifo [2][2];
  int         m_size [2];
  logic [7:0] m_out  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic c, input logic v,
                              input logic d, input logic o);
    for (int unsigned k = 0; k < 2; k++) begin
      bit         rdy, acc, cons, done;
      int         pos;
      logic [7:0] w;
      if (r) begin
        m_cnt[k] = 0; m_asm[k] = '0; m_size[k] = 0; m_out[k] = '0;
        continue;
      end
      rdy  = (m_size[k] < 2);
      acc  = v && rdy && !c;
      cons = (m_size[k] > 0) && o;
      done = 1'b0;
      w    = '0;
      if (acc) begin
        pos = (k == 0) ? 7 - m_cnt[k] : m_cnt[k];
        m_asm[k][pos] = d;
        if (m_cnt[k] == 7) begin
          done = 1'b1;
          w    = m_asm[k];
        end
        m_cnt[k] = (m_cnt[k] + 1) % 8;
      end
      if (c) begin
        m_cnt[k] = 0;
        m_asm[k] = '0;
      end
      if (cons) begin
        m_fifo[k][0] = m_fifo[k][1];
        m_size[k]--;
      end
      if (done) begin
        m_fifo[k][m_size[k]] = w;
        m_size[k]++;
      end
      if (m_size[k] > 0) m_out[k] = m_fifo[k][0];
    end
  endtask

  task automatic check_all();
    chk("m_valid", 32'(bus_m.out_valid), 32'(m_size[0] > 0));
    chk("m_ready", 32'(bus_m.din_ready), 32'(m_size[0] < 2));
    chk("m_data",  32'(bus_m.out_data),  32'(m_out[0]));
    chk("m_slot",  32'(bus_m.slot),      32'(7 - m_cnt[0]));
    chk("l_valid", 32'(bus_l.out_valid), 32'(m_size[1] > 0));
    chk("l_ready", 32'(bus_l.din_ready), 32'(m_size[1] < 2));
    chk("l_data",  32'(bus_l.out_data),  32'(m_out[1]));
    chk("l_slot",  32'(bus_l.slot),      32'(m_cnt[1]));
  endtask

  task automatic step(input logic r, input logic c, input logic v,
                      input logic d, input logic o);
    rst = r;
    bus_m.clr = c; bus_m.din_valid = v; bus_m.din = d; bus_m.out_ready = o;
    bus_l.clr = c; bus_l.din_valid = v; bus_l.din = d; bus_l.out_ready = o;
    @(posedge clk);
    model_update(r, c, v, d, o);
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [7:0] w, input logic o);
    for (int i = 7; i >= 0; i--) step(1'b0, 1'b0, 1'b1, w[i], o);
  endtask

  initial begin
    bus_m.clr = 1'b0; bus_m.din_valid = 1'b0; bus_m.din = 1'b0; bus_m.out_ready = 1'b0;
    bus_l.clr = 1'b0; bus_l.din_valid = 1'b0; bus_l.din = 1'b0; bus_l.out_ready = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_asm[k] = '0; m_size[k] = 0; m_out[k] = '0;
      m_fifo[k][0] = '0; m_fifo[k][1] = '0;
    end

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_slot_m", 32'(bus_m.slot), 32'd7);
    chk("rst_slot_l", 32'(bus_l.slot), 32'd0);
    chk("rst_ready", 32'(bus_m.din_ready), 32'd1);
    chk("rst_valid", 32'(bus_m.out_valid), 32'd0);

    // One word 1,0,1,1,0,0,1,0 with consumer always ready.
    send_word(8'hB2, 1'b1);
    chk("word_msb", 32'(bus_m.out_data), 32'h0000_00B2);
    chk("word_lsb", 32'(bus_l.out_data), 32'h0000_004D);
    chk("word_valid", 32'(bus_m.out_valid), 32'd1);
    chk("lsb_wrap_slot", 32'(bus_l.slot), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("word_pulse", 32'(bus_m.out_valid), 32'd0);

    // Backpressure: two words fill output and staging.
    send_word(8'hB2, 1'b0);
    send_word(8'h5A, 1'b0);
    chk("bp_ready", 32'(bus_m.din_ready), 32'd0);
    chk("bp_hold", 32'(bus_m.out_data), 32'h0000_00B2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("bp_stable", 32'(bus_m.out_data), 32'h0000_00B2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_drain", 32'(bus_m.out_data), 32'h0000_005A);
    chk("bp_drain_v", 32'(bus_m.out_valid), 32'd1);
    chk("bp_drain_r", 32'(bus_m.din_ready), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_empty", 32'(bus_m.out_valid), 32'd0);

    // Back-to-back words, consumer always ready.
    for (int n = 0; n < 4; n++) send_word(8'($urandom), 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Clear mid-word, with a bit offered in the same cycle.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_slot", 32'(bus_m.slot), 32'd7);
    send_word(8'h0F, 1'b1);
    chk("clr_word", 32'(bus_m.out_data), 32'h0000_000F);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic with occasional clears.
    for (int n = 0; n < 400; n++)
      step(1'b0, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));

    // Reset while both output and staging are occupied.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'hB2, 1'b0);
    send_word(8'h5A, 1'b0);
    chk("full_ready", 32'(bus_m.din_ready), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("mid_rst_valid", 32'(bus_m.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus_m.din_ready), 32'd1);
    chk("mid_rst_slot", 32'(bus_m.slot), 32'd7);
    chk("mid_rst_data", 32'(bus_m.out_data), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
